// File: rtl/pi_leaf_interface_pkg.sv
// Shared types and helpers for the pi-switch leaf interface.
// Holds the inject-source select and the saturating counter increment.
package pi_leaf_interface_pkg;

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    InjNone,
    InjBounce,
    InjTx
  } inj_sel_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt);
    return (cnt == CntMax) ? cnt : cnt + CntW'(1);
  endfunction

endpackage

// File: rtl/pi_leaf_fifo.sv
// Show-ahead synchronous FIFO with asynchronous active-high reset.
// Pointers carry one extra MSB so full and empty can be told apart.
module pi_leaf_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned aw = $clog2(depth);

  logic [aw:0]      wptr_q, rptr_q;
  logic [width-1:0] mem_q [depth];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot at the same edge, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q[aw-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[aw-1:0]] <= wdata;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pi_leaf_interface.sv
// Leaf endpoint of the pi-switch BFT: buffers PE packets for injection, bounces
// misrouted arrivals back into the network and buffers payloads addressed here.
module pi_leaf_interface
  import pi_leaf_interface_pkg::*;
#(
  parameter int unsigned num_leaves = 2,
  parameter int unsigned payload_sz = 1,
  parameter int unsigned addr       = 0,
  parameter int unsigned p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int unsigned tx_depth   = 4,
  parameter int unsigned rx_depth   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [p_sz-1:0]               bus_o,
  input  logic [p_sz-1:0]               bus_i,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [$clog2(num_leaves)-1:0] tx_dest,
  input  logic [payload_sz-1:0]         tx_payload,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [payload_sz-1:0]         rx_payload,
  output logic [CntW-1:0]               drop_cnt,
  output logic [CntW-1:0]               bounce_cnt
);

  localparam int unsigned aw = $clog2(num_leaves);
  localparam logic [aw-1:0] my_addr = aw'(addr);

  logic            in_valid, in_match, in_bounce;
  logic [aw-1:0]   in_dest;
  logic            tx_push, tx_pop, tx_empty, tx_full;
  logic [p_sz-1:0] tx_head;
  logic            rx_pop, rx_empty, rx_full, drop;
  logic            ready_q;
  inj_sel_e        inj_sel;
  logic [p_sz-1:0] bus_d, bus_q;
  logic [CntW-1:0] drop_q, bounce_q;

  assign in_valid  = bus_i[p_sz-1];
  assign in_dest   = bus_i[p_sz-2 -: aw];
  assign in_match  = in_valid && (in_dest == my_addr);
  assign in_bounce = in_valid && (in_dest != my_addr);

  // Held low through reset and for the first edge after release.
  assign tx_ready = ready_q && !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (inj_sel == InjTx);

  pi_leaf_fifo #(
    .width(p_sz),
    .depth(tx_depth)
  ) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (tx_push),
    .wdata({1'b1, tx_dest, tx_payload}),
    .pop  (tx_pop),
    .rdata(tx_head),
    .empty(tx_empty),
    .full (tx_full)
  );

  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign drop     = in_match && rx_full && !rx_pop;

  pi_leaf_fifo #(
    .width(payload_sz),
    .depth(rx_depth)
  ) u_rx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (in_match),
    .wdata(bus_i[payload_sz-1:0]),
    .pop  (rx_pop),
    .rdata(rx_payload),
    .empty(rx_empty),
    .full (rx_full)
  );

  // Bounces take priority: the network cannot hold them anywhere else.
  always_comb begin
    inj_sel = InjNone;
    if (in_bounce)     inj_sel = InjBounce;
    else if (!tx_empty) inj_sel = InjTx;
  end

  always_comb begin
    bus_d = '0;
    unique case (inj_sel)
      InjBounce: bus_d = bus_i;
      InjTx:     bus_d = tx_head;
      default:   bus_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q    <= '0;
      ready_q  <= 1'b0;
      drop_q   <= '0;
      bounce_q <= '0;
    end else begin
      bus_q   <= bus_d;
      ready_q <= 1'b1;
      if (drop)      drop_q   <= sat_inc(drop_q);
      if (in_bounce) bounce_q <= sat_inc(bounce_q);
    end
  end

  assign bus_o      = bus_q;
  assign drop_cnt   = drop_q;
  assign bounce_cnt = bounce_q;

endmodule
